// File: rtl/systolic_tile_scheduler.sv
// Tile scheduler for the 8x8 systolic-array driver: walks C tiles (i,j) and K-tiles (k),
// launches the driver per tile and streams result rows to memory. Optional: SCHED_PERF_COUNT_EN.
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module systolic_tile_scheduler #(
  parameter int TILE = 8
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [`DIM_WIDTH-1:0]                    dim_M,
  input  logic [`DIM_WIDTH-1:0]                    dim_K,
  input  logic [`DIM_WIDTH-1:0]                    dim_N,
  input  logic [`ADDR_WIDTH-1:0]                   base_A,
  input  logic [`ADDR_WIDTH-1:0]                   base_B,
  input  logic [`ADDR_WIDTH-1:0]                   base_C,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic                                     sa_start,
  output logic [`ADDR_WIDTH-1:0]                   sa_base_A,
  output logic [`ADDR_WIDTH-1:0]                   sa_base_B,
  output logic [`DIM_WIDTH-1:0]                    sa_dim_col_A,
  output logic [`DIM_WIDTH-1:0]                    sa_dim_col_B,
  input  logic                                     sa_done,
  input  logic [7:0][7:0][`DATA_WIDTH-1:0]         sa_out,
`ifdef SCHED_PERF_COUNT_EN
  output logic [31:0]                              perf_cycles,
  output logic [31:0]                              perf_stall,
`endif
  output logic                                     write,
  input  logic                                     write_ready,
  output logic                                     write_accum,
  output logic [`ADDR_WIDTH-1:0]                   write_addr,
  output logic [7:0][`DATA_WIDTH-1:0]              writedata
);

  localparam int DW = `DIM_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int unsigned TSHIFT = $clog2(TILE);
  localparam logic [AW-1:0] TILE_A = AW'(TILE);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LAUNCH, S_WAIT_SA, S_WRITE, S_NEXT, S_FIN
  } state_t;

  state_t        state;
  logic [DW-1:0] m_r, k_r, n_r;
  logic [AW-1:0] a_r, b_r, c_r;
  logic [DW-1:0] ti, tj, tk;
  logic [2:0]    row;

  logic [DW-1:0] i_last, j_last, k_last, ni, nj, nk;
  logic          i_wrap, j_wrap, k_wrap, dims_bad;
  logic [AW-1:0] launch_a, launch_b, row0_addr;
  logic [2:0]    row_nx;

  assign sa_dim_col_A = k_r;
  assign sa_dim_col_B = n_r;

  always_comb begin
    i_last = (m_r >> TSHIFT) - DW'(1);
    j_last = (n_r >> TSHIFT) - DW'(1);
    k_last = (k_r >> TSHIFT) - DW'(1);
    k_wrap = (tk == k_last);
    j_wrap = (tj == j_last);
    i_wrap = (ti == i_last);
    nk = k_wrap ? '0 : tk + DW'(1);
    nj = k_wrap ? (j_wrap ? '0 : tj + DW'(1)) : tj;
    ni = (k_wrap && j_wrap) ? (i_wrap ? '0 : ti + DW'(1)) : ti;
    // Launch bases are computed from the post-increment indices so sa_start is high in LAUNCH.
    launch_a  = a_r + TILE_A * AW'(ni) * AW'(k_r) + TILE_A * AW'(nk);
    launch_b  = b_r + TILE_A * AW'(nk) * AW'(n_r) + TILE_A * AW'(nj);
    row0_addr = c_r + TILE_A * AW'(ti) * AW'(n_r) + TILE_A * AW'(tj);
    row_nx    = row + 3'd1;
    dims_bad  = (m_r == '0) || (k_r == '0) || (n_r == '0) ||
                (m_r[TSHIFT-1:0] != '0) || (k_r[TSHIFT-1:0] != '0) || (n_r[TSHIFT-1:0] != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      m_r         <= '0;
      k_r         <= '0;
      n_r         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      ti          <= '0;
      tj          <= '0;
      tk          <= '0;
      row         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      sa_start    <= 1'b0;
      sa_base_A   <= '0;
      sa_base_B   <= '0;
      write       <= 1'b0;
      write_accum <= 1'b0;
      write_addr  <= '0;
      writedata   <= '0;
    end else begin
      sa_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          m_r   <= dim_M;
          k_r   <= dim_K;
          n_r   <= dim_N;
          a_r   <= base_A;
          b_r   <= base_B;
          c_r   <= base_C;
          busy  <= 1'b1;
          error <= 1'b0;
          state <= S_CHECK;
        end
        S_CHECK: if (dims_bad) begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_FIN;
        end else begin
          ti        <= '0;
          tj        <= '0;
          tk        <= '0;
          sa_start  <= 1'b1;
          sa_base_A <= a_r;
          sa_base_B <= b_r;
          state     <= S_LAUNCH;
        end
        S_LAUNCH: state <= S_WAIT_SA;
        S_WAIT_SA: if (sa_done) begin
          write       <= 1'b1;
          write_accum <= (tk != '0);
          write_addr  <= row0_addr;
          writedata   <= sa_out[0];
          row         <= '0;
          state       <= S_WRITE;
        end
        S_WRITE: if (write_ready) begin
          if (row == 3'd7) begin
            write       <= 1'b0;
            write_accum <= 1'b0;
            state       <= S_NEXT;
          end else begin
            row        <= row_nx;
            write_addr <= write_addr + AW'(n_r);
            writedata  <= sa_out[row_nx];
          end
        end
        S_NEXT: begin
          ti <= ni;
          tj <= nj;
          tk <= nk;
          if (k_wrap && j_wrap && i_wrap) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            sa_start  <= 1'b1;
            sa_base_A <= launch_a;
            sa_base_B <= launch_b;
            state     <= S_LAUNCH;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state == S_WRITE && !write_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed self-checking bench for systolic_tile_scheduler with a behavioural driver responder.
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_systolic_tile_scheduler;
  localparam int DW = `DIM_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int XW = `DATA_WIDTH;

  logic                     clock, reset, start;
  logic [DW-1:0]            dim_M, dim_K, dim_N;
  logic [AW-1:0]            base_A, base_B, base_C;
  logic                     busy, done, error, sa_start;
  logic [AW-1:0]            sa_base_A, sa_base_B;
  logic [DW-1:0]            sa_dim_col_A, sa_dim_col_B;
  logic                     sa_done;
  logic [7:0][7:0][XW-1:0]  sa_out;
  logic                     write, write_ready, write_accum;
  logic [AW-1:0]            write_addr;
  logic [7:0][XW-1:0]       writedata;

  systolic_tile_scheduler #(.TILE(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dim_M(dim_M), .dim_K(dim_K), .dim_N(dim_N),
    .base_A(base_A), .base_B(base_B), .base_C(base_C),
    .busy(busy), .done(done), .error(error),
    .sa_start(sa_start), .sa_base_A(sa_base_A), .sa_base_B(sa_base_B),
    .sa_dim_col_A(sa_dim_col_A), .sa_dim_col_B(sa_dim_col_B),
    .sa_done(sa_done), .sa_out(sa_out),
    .write(write), .write_ready(write_ready), .write_accum(write_accum),
    .write_addr(write_addr), .writedata(writedata)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int tile_id  = 0;
  int done_cnt = 0;

  logic [AW-1:0]      wa_q[$];
  logic               wacc_q[$];
  logic [7:0][XW-1:0] wd_q[$];
  logic [AW-1:0]      saa_q[$];
  logic [AW-1:0]      sab_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0][XW-1:0] pat(input int t, input int r);
    logic [7:0][XW-1:0] res;
    for (int c = 0; c < 8; c++) res[c] = XW'((t << 8) | (r << 4) | c);
    return res;
  endfunction

  // Driver model: result appears ~30 cycles after each sa_start.
  initial begin
    sa_done = 1'b0;
    sa_out  = '0;
    forever begin
      @(negedge clock);
      if (sa_start) begin
        sa_out = '0;
        repeat (29) @(negedge clock);
        for (int r = 0; r < 8; r++) sa_out[r] = pat(tile_id, r);
        sa_done = 1'b1;
        @(negedge clock);
        sa_done = 1'b0;
        tile_id++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (write && write_ready) begin
        wa_q.push_back(write_addr);
        wacc_q.push_back(write_accum);
        wd_q.push_back(writedata);
      end
      if (sa_start) begin
        saa_q.push_back(sa_base_A);
        sab_q.push_back(sa_base_B);
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wacc_q.delete(); wd_q.delete(); saa_q.delete(); sab_q.delete();
    tile_id = 0;
  endtask

  task automatic run_job(input int m, input int k, input int n, input int a, input int b,
                         input int c, input bit tog, input bit inject);
    bit got;
    clear_logs();
    @(negedge clock);
    dim_M = DW'(m); dim_K = DW'(k); dim_N = DW'(n);
    base_A = AW'(a); base_B = AW'(b); base_C = AW'(c);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    got = 0;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      @(negedge clock);
      if (tog) write_ready = ~write_ready;
      if (inject && cyc == 40) begin
        dim_M = 16; dim_K = 16; dim_N = 16;
        base_A = 7; base_B = 9; base_C = 11;
        start = 1'b1;
      end
      if (inject && cyc == 41) start = 1'b0;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("job_error", error, 0);
    write_ready = 1'b1;
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic check_two_tile(input int a, input int b, input int c);
    chk("t2_sa_count", saa_q.size(), 2);
    if (saa_q.size() == 2) begin
      chk("t2_saA0", saa_q[0], AW'(a));
      chk("t2_saA1", saa_q[1], AW'(a + 8));
      chk("t2_saB0", sab_q[0], AW'(b));
      chk("t2_saB1", sab_q[1], AW'(b + 64));
    end
    chk("t2_beats", wa_q.size(), 16);
    for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), wa_q[i], AW'(c + 8 * (i % 8)));
      chk($sformatf("t2_acc%0d", i), wacc_q[i], (i >= 8));
      chk($sformatf("t2_data%0d", i), wd_q[i], pat(i / 8, i % 8));
    end
  endtask

  initial begin
    int exp_a[6];
    int exp_b[6];
    int exp_c[6];
    int d0;
    int q0;
    bit seen;
    exp_a = '{0, 0, 0, 64, 64, 64};
    exp_b = '{256, 264, 272, 256, 264, 272};
    exp_c = '{4096, 4104, 4112, 4288, 4296, 4304};

    reset = 1'b1; start = 1'b0; write_ready = 1'b1;
    dim_M = '0; dim_K = '0; dim_N = '0; base_A = '0; base_B = '0; base_C = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_sa_start", sa_start, 0);
    chk("rst_write", write, 0);
    chk("rst_write_accum", write_accum, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_sa_base_A", sa_base_A, 0);
    chk("rst_sa_dim_col_B", sa_dim_col_B, 0);
    reset = 1'b0;

    // Single tile
    run_job(8, 8, 8, 0, 64, 128, 0, 0);
    chk("t1_sa_count", saa_q.size(), 1);
    if (saa_q.size() == 1) begin
      chk("t1_saA", saa_q[0], 0);
      chk("t1_saB", sab_q[0], 64);
    end
    chk("t1_dim_col_A", sa_dim_col_A, 8);
    chk("t1_beats", wa_q.size(), 8);
    for (int r = 0; r < 8 && r < wa_q.size(); r++) begin
      chk($sformatf("t1_addr%0d", r), wa_q[r], AW'(128 + 8 * r));
      chk($sformatf("t1_acc%0d", r), wacc_q[r], 0);
      chk($sformatf("t1_data%0d", r), wd_q[r], pat(0, r));
    end

    // Two K-partials, second accumulates
    run_job(8, 16, 8, 1000, 2000, 3000, 0, 0);
    check_two_tile(1000, 2000, 3000);

    // 2x3 output tiles, i outer / j inner
    run_job(16, 8, 24, 0, 256, 4096, 0, 0);
    chk("t3_sa_count", saa_q.size(), 6);
    chk("t3_beats", wa_q.size(), 48);
    for (int t = 0; t < 6 && t < saa_q.size(); t++) begin
      chk($sformatf("t3_saA%0d", t), saa_q[t], AW'(exp_a[t]));
      chk($sformatf("t3_saB%0d", t), sab_q[t], AW'(exp_b[t]));
    end
    for (int t = 0; t < 6 && 8 * t + 7 < wa_q.size(); t++) begin
      chk($sformatf("t3_first%0d", t), wa_q[8 * t], AW'(exp_c[t]));
      chk($sformatf("t3_last%0d", t), wa_q[8 * t + 7], AW'(exp_c[t] + 168));
      chk($sformatf("t3_acc%0d", t), wacc_q[8 * t], 0);
      chk($sformatf("t3_data%0d", t), wd_q[8 * t + 3], pat(t, 3));
    end

    // Bad dimensions: K not a multiple of 8, then N == 0
    for (int v = 0; v < 2; v++) begin
      clear_logs();
      @(negedge clock);
      dim_M = 8; dim_K = (v == 0) ? 12 : 8; dim_N = (v == 0) ? 8 : 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk($sformatf("bad%0d_done_c1", v), done, 0);
      @(negedge clock);
      chk($sformatf("bad%0d_done_c2", v), done, 1);
      chk($sformatf("bad%0d_error", v), error, 1);
      @(negedge clock);
      chk($sformatf("bad%0d_busy", v), busy, 0);
      chk($sformatf("bad%0d_no_sa", v), saa_q.size(), 0);
      chk($sformatf("bad%0d_no_write", v), wa_q.size(), 0);
    end

    // Backpressure plus an ignored mid-job start
    d0 = done_cnt;
    run_job(8, 16, 8, 500, 600, 700, 1, 1);
    check_two_tile(500, 600, 700);
    repeat (3) @(negedge clock);
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_idle_after", busy, 0);

    // Reset in the middle of WRITE
    clear_logs();
    @(negedge clock);
    dim_M = 8; dim_K = 8; dim_N = 8; base_A = 0; base_B = 0; base_C = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clock);
      if (write) seen = 1;
    end
    chk("rstw_write_seen", seen, 1);
    write_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rstw_write", write, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_addr", write_addr, 0);
    d0 = done_cnt;
    q0 = wa_q.size();
    @(negedge clock);
    reset = 1'b0;
    write_ready = 1'b1;
    repeat (40) @(negedge clock);
    chk("rstw_no_done", done_cnt - d0, 0);
    chk("rstw_no_write", wa_q.size() - q0, 0);
    chk("rstw_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
